inst_rom_arbiter: RTL and testbench
===================================

# inst_rom_arbiter

Shares the single instruction ROM between two requesters: the fetch path (port F, driven by the PC register) and a debug/loader read port (port D). Sits between `pc_reg` and `rom`. It owns the ROM's `ce`/`addr` inputs, arbitrates per cycle, supports locked bursts on port D, and registers the read data with a fixed one-cycle return latency.

## Interface
- `ADDR_W`, 6, ROM word-address width.
- `DATA_W`, 32, instruction width.
- `MAX_BURST`, 4, maximum consecutive port-D grants under lock (≥1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `f_req`  in  1  fetch read request.
- `f_addr`  in  ADDR_W  fetch word address.
- `f_gnt`  out  1  fetch granted this cycle (combinational).
- `f_rvalid`  out  1  `f_rdata` valid (registered).
- `f_rdata`  out  DATA_W  fetch read data (registered).
- `d_req`  in  1  debug read request.
- `d_lock`  in  1  hold the grant on D for consecutive cycles.
- `d_addr`  in  ADDR_W  debug word address.
- `d_gnt`  out  1  debug granted this cycle (combinational).
- `d_rvalid`  out  1  `d_rdata` valid (registered).
- `d_rdata`  out  DATA_W  debug read data (registered).
- `rom_ce`  out  1  ROM chip enable.
- `rom_addr`  out  ADDR_W  ROM address.
- `rom_inst`  in  DATA_W  ROM data, combinational from `rom_addr`.

## Operation
- At most one grant per cycle; `f_gnt & d_gnt` is never 1.
- Grant requires the matching `*_req`. When a port is granted: `rom_ce=1` and `rom_addr` = that port's address. With no grant: `rom_ce=0`, `rom_addr=0`.
- States: ARB, D_LOCK.
- ARB, round-robin: if exactly one port requests, it wins. If both request, the port that did not win the most recent arbitrated cycle wins. The `last` flop resets to D, so F wins the first tie.
- ARB → D_LOCK: D is granted with `d_lock=1` and `MAX_BURST>1`. `burst_cnt` is loaded with 1.
- D_LOCK: D is granted while `d_req & d_lock` and `burst_cnt < MAX_BURST`; each grant increments `burst_cnt`. F is not granted, even if it requests.
- D_LOCK → ARB: any of `!d_req`, `!d_lock`, or `burst_cnt == MAX_BURST`.
  - The cycle in which the exit condition holds is arbitrated as in ARB.
  - When the exit is `burst_cnt == MAX_BURST`, `last=D`, so F wins a tie in that cycle.
- `burst_cnt` is ceil(log2(MAX_BURST+1)) bits wide and never wraps.
- Read data: on each edge, a granted port's `*_rdata <= rom_inst` and its `*_rvalid <= 1`. A non-granted port's `*_rvalid <= 0` and its `*_rdata` holds its value.
- The arbiter does not retain requests; a requester keeps `*_req` and its address stable until granted.

## Timing
- Reset (`rst`=0, asynchronous):
  - Forces state ARB, `last=D`, `burst_cnt=0`.
  - Forces `f_rvalid=d_rvalid=0` and `f_rdata=d_rdata=0`.
  - Combinational outputs follow their inputs from the reset state.
  - Reset asserted mid-burst aborts the burst immediately; no `rvalid` for the aborted cycle's data.
- Grant-to-data latency: exactly 1 cycle. Data for a grant in cycle N appears with `rvalid=1` in cycle N+1.
- Throughput: one read per cycle total. Back-to-back grants to the same port give continuous `rvalid`.
- Both requesters continuously active with `d_lock=0` → strict alternation F, D, F, D.
- `d_lock` is sampled only while `d_req=1`; `d_lock` without `d_req` has no effect.

## Configuration
- `INST_ROM_ARB_FETCH_PRIO_EN`
  - Defined: F has fixed priority in ARB. On a tie F always wins, and `last` is unused. D_LOCK is entered only when F is not requesting, but once entered it still blocks F until exit.
  - Undefined: round-robin as above.

## Test plan
- Reset and idle:
  - Drive `rst`=0 mid-cycle with `f_req=1` → `f_rvalid=d_rvalid=0`, `f_rdata=d_rdata=0` immediately.
  - With `rst`=1 and no requests → `rom_ce=0`, `rom_addr=0`.
- Single fetch: `f_req=1`, `f_addr=5`, ROM word 5 = 0x34011100 → same cycle `f_gnt=1`, `rom_addr=5`; next cycle `f_rvalid=1`, `f_rdata=0x34011100`.
- Contention (round-robin): `f_req=d_req=1` for 4 cycles, `d_lock=0` → grants F, D, F, D; the `rvalid` pulses follow the same pattern one cycle later.
- Locked burst:
  - Setup: `MAX_BURST=4`, `d_req=d_lock=1`, `f_req=1` for 7 cycles.
  - Required grants: D, D, D, D, F, D, D. The second group of D grants is a new lock starting after F.
  - Exit on `d_lock=0` mid-burst → F is granted the same cycle.
- Reset mid-burst: assert `rst` after the 2nd D grant → `d_rvalid=0` at once; after release, a tie is granted to F first.
- With `INST_ROM_ARB_FETCH_PRIO_EN`: both ports requesting for 3 cycles → grants F, F, F; `d_gnt` stays 0 until `f_req=0`.

Source files
------------

// File: rtl/inst_rom_arbiter.sv
// Instruction-ROM arbiter between the fetch port (F) and a debug/loader port (D), with locked D bursts.
// Define INST_ROM_ARB_FETCH_PRIO_EN for fixed fetch priority on ties; otherwise ties are round-robin.
module inst_rom_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit LOCK_EN = (MAX_BURST > 1);

    typedef enum logic {
        ARB,
        D_LOCK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_next;
    logic             lock_hold;

`ifndef INST_ROM_ARB_FETCH_PRIO_EN
    // Set when D won the most recent arbitrated cycle; F wins the next tie.
    logic last_d;
    logic last_d_next;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
        end
    end

`ifndef INST_ROM_ARB_FETCH_PRIO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b1;
        end else begin
            last_d <= last_d_next;
        end
    end
`endif

    // A locked burst keeps D only while it still asks for the lock and has budget left;
    // otherwise the cycle falls through to ordinary arbitration.
    always_comb begin
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        lock_hold = 1'b0;
        if (state == D_LOCK && d_req && d_lock && burst_cnt < CNT_MAX) begin
            lock_hold = 1'b1;
            d_gnt     = 1'b1;
        end else if (f_req && d_req) begin
`ifdef INST_ROM_ARB_FETCH_PRIO_EN
            f_gnt = 1'b1;
`else
            f_gnt = last_d;
            d_gnt = !last_d;
`endif
        end else begin
            f_gnt = f_req;
            d_gnt = d_req;
        end
    end

    always_comb begin
        state_next     = ARB;
        burst_cnt_next = '0;
        if (lock_hold) begin
            state_next     = D_LOCK;
            burst_cnt_next = burst_cnt + CNT_ONE;
        end else if (LOCK_EN && d_gnt && d_lock) begin
            state_next     = D_LOCK;
            burst_cnt_next = CNT_ONE;
        end
    end

`ifndef INST_ROM_ARB_FETCH_PRIO_EN
    always_comb begin
        last_d_next = last_d;
        if (f_gnt) begin
            last_d_next = 1'b0;
        end else if (d_gnt) begin
            last_d_next = 1'b1;
        end
    end
`endif

    always_comb begin
        rom_ce   = f_gnt | d_gnt;
        rom_addr = '0;
        if (f_gnt) begin
            rom_addr = f_addr;
        end else if (d_gnt) begin
            rom_addr = d_addr;
        end
    end

    // Read data is captured at the grant edge, giving a fixed one-cycle return latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= f_gnt;
            d_rvalid <= d_gnt;
            if (f_gnt) begin
                f_rdata <= rom_inst;
            end
            if (d_gnt) begin
                d_rdata <= rom_inst;
            end
        end
    end

    one_grant_a : assert property (@(posedge clk) disable iff (!rst) !(f_gnt && d_gnt));

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Randomized bench for inst_rom_arbiter: a behavioural model predicts grants and read data every cycle,
// and directed sequences pin reset, single fetch, round-robin, locked burst and reset-mid-burst cases.
module tb_inst_rom_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req = 1'b0;
    logic          d_lock = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst;

    logic [DW-1:0] rom_mem [64];

    int checks = 0;
    int errors = 0;

    // Model state: length of the current locked D run (0 = none) and who won last.
    int            lock_run = 0;
    logic          last_d = 1'b1;
    logic          m_frv = 1'b0;
    logic          m_drv = 1'b0;
    logic [DW-1:0] m_frd = '0;
    logic [DW-1:0] m_drd = '0;
    logic [1:0]    exp_g;
    logic          exp_in_lock;

    inst_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_lock(d_lock), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    always #5 clk = ~clk;

    assign rom_inst = rom_mem[rom_addr];

    // Returns {F granted, D granted}.
    function automatic logic [1:0] pick(input logic fr, input logic dr, input logic dl,
                                        input int run, input logic ld);
        if (run > 0 && run < MB && dr && dl) return 2'b01;
        if (fr && dr) begin
`ifdef INST_ROM_ARB_FETCH_PRIO_EN
            return 2'b10;
`else
            return ld ? 2'b10 : 2'b01;
`endif
        end
        return {fr, dr};
    endfunction

    assign exp_g       = pick(f_req, d_req, d_lock, lock_run, last_d);
    assign exp_in_lock = (lock_run > 0 && lock_run < MB && d_req && d_lock);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_run <= 0;
            last_d   <= 1'b1;
            m_frv    <= 1'b0;
            m_drv    <= 1'b0;
            m_frd    <= '0;
            m_drd    <= '0;
        end else begin
            m_frv <= exp_g[1];
            m_drv <= exp_g[0];
            if (exp_g[1]) begin
                m_frd    <= rom_mem[f_addr];
                last_d   <= 1'b0;
                lock_run <= 0;
            end else if (exp_g[0]) begin
                m_drd    <= rom_mem[d_addr];
                last_d   <= 1'b1;
                lock_run <= !d_lock ? 0 : (exp_in_lock ? lock_run + 1 : 1);
            end else begin
                lock_run <= 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("f_gnt", 64'(f_gnt), 64'(exp_g[1]));
        check_output("d_gnt", 64'(d_gnt), 64'(exp_g[0]));
        check_output("rom_ce", 64'(rom_ce), 64'(exp_g[1] | exp_g[0]));
        check_output("rom_addr", 64'(rom_addr), exp_g[1] ? 64'(f_addr) : (exp_g[0] ? 64'(d_addr) : 64'd0));
        check_output("f_rvalid", 64'(f_rvalid), 64'(m_frv));
        check_output("f_rdata", 64'(f_rdata), 64'(m_frd));
        check_output("d_rvalid", 64'(d_rvalid), 64'(m_drv));
        check_output("d_rdata", 64'(d_rdata), 64'(m_drd));
    end

    task automatic apply_stimulus(input logic fr, input logic [AW-1:0] fa,
                                  input logic dr, input logic dl, input logic [AW-1:0] da);
        @(posedge clk);
        #1;
        f_req  = fr;
        f_addr = fa;
        d_req  = dr;
        d_lock = dl;
        d_addr = da;
    endtask

    logic [1:0] rr_exp [4];
    logic [1:0] burst_exp [7];

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
        rom_mem[5] = 32'h3401_1100;
        rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`ifdef INST_ROM_ARB_FETCH_PRIO_EN
        burst_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`else
        burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
`endif

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("idle_rom_ce", 64'(rom_ce), 64'd0);
        check_output("idle_rom_addr", 64'(rom_addr), 64'd0);

        apply_stimulus(1'b1, 6'd5, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        check_output("fetch_gnt", 64'({f_gnt, d_gnt}), 64'b10);
        check_output("fetch_rom_addr", 64'(rom_addr), 64'd5);
        apply_stimulus(1'b1, 6'd5, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        check_output("fetch_rvalid", 64'(f_rvalid), 64'd1);
        check_output("fetch_rdata", 64'(f_rdata), 64'h3401_1100);

        #3 rst = 1'b0;
        #1;
        check_output("rst_f_rvalid", 64'(f_rvalid), 64'd0);
        check_output("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        check_output("rst_f_rdata", 64'(f_rdata), 64'd0);
        check_output("rst_d_rdata", 64'(d_rdata), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        f_req = 1'b0;

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 6'd7, 1'b1, 1'b0, 6'd9);
            @(negedge clk);
            check_output("rr_gnt", 64'({f_gnt, d_gnt}), 64'(rr_exp[i]));
        end

        apply_stimulus(1'b1, 6'd3, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        check_output("pre_burst_gnt", 64'({f_gnt, d_gnt}), 64'b10);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b1, 6'd3, 1'b1, 1'b1, 6'd12);
            @(negedge clk);
            check_output("burst_gnt", 64'({f_gnt, d_gnt}), 64'(burst_exp[i]));
        end
        apply_stimulus(1'b1, 6'd3, 1'b1, 1'b0, 6'd12);
        @(negedge clk);
        check_output("unlock_gnt", 64'({f_gnt, d_gnt}), 64'b10);

        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 6'd0, 1'b1, 1'b1, 6'd20);
            @(negedge clk);
            check_output("lock_d_gnt", 64'({f_gnt, d_gnt}), 64'b01);
        end
        @(posedge clk);
        #3;
        f_req = 1'b1;
        rst   = 1'b0;
        #1;
        check_output("rst_burst_d_rvalid", 64'(d_rvalid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("post_rst_tie_gnt", 64'({f_gnt, d_gnt}), 64'b10);

        for (int i = 0; i < 2000; i++) begin
            apply_stimulus(($urandom_range(0, 9) < 6), AW'($urandom), ($urandom_range(0, 9) < 6),
                           $urandom_range(0, 1) == 1, AW'($urandom));
        end
        apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
